// File: rtl/fpu_64_divider.sv
// fpu_64_divider: IEEE-754 binary64 divider, restoring radix-2, fixed 57-cycle start-to-done latency.
// Ports: clk, rst (sync, active-high); X dividend, Y divisor, start request;
// res quotient, overflow_flag, underflow_flag, div_by_zero_flag, busy, done (all registered).
// Build option: define FPU64_DIV_ROUND_EN for round-to-nearest-even, otherwise truncation.
module fpu_64_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] X,
  input  logic [63:0] Y,
  input  logic        start,
  output logic [63:0] res,
  output logic        overflow_flag,
  output logic        underflow_flag,
  output logic        div_by_zero_flag,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, DIVIDE, NORMALIZE, DONE} state_t;
  state_t             r_state;
  logic        [5:0]  r_cnt;
  logic               r_sign;
  logic               r_xz;
  logic               r_yz;
  logic signed [12:0] r_exp;
  logic        [53:0] r_my;
  logic        [53:0] r_rem;
  logic        [54:0] r_q;
  logic               w_ge;
  logic        [53:0] w_sub;
  logic               w_hi;
  logic        [51:0] w_mant;
  logic signed [12:0] w_e0;
  logic        [51:0] w_mf;
  logic signed [12:0] w_ef;
  logic               w_ov;
  logic               w_un;
  logic        [63:0] w_res;
  // exponent kept one bit wider than the field difference so huge quotients cannot wrap
  always_comb begin
    w_ge   = r_rem >= r_my;
    w_sub  = w_ge ? r_rem - r_my : r_rem;
    w_hi   = r_q[54];
    w_mant = w_hi ? r_q[53:2] : r_q[52:1];
    w_e0   = w_hi ? r_exp : r_exp - 13'sd1;
  end
`ifdef FPU64_DIV_ROUND_EN
  logic        w_g;
  logic        w_s;
  logic [52:0] w_sum;
  always_comb begin
    w_g   = w_hi ? r_q[1] : r_q[0];
    w_s   = (w_hi & r_q[0]) | (|r_rem);
    w_sum = {1'b0, w_mant} + {52'd0, w_g & (w_s | w_mant[0])};
    w_mf  = w_sum[51:0];
    w_ef  = w_e0 + $signed({12'd0, w_sum[52]});
  end
`else
  logic w_unused;
  always_comb begin
    w_unused = r_q[0];
    w_mf     = w_mant;
    w_ef     = w_e0;
  end
`endif
  always_comb begin
    w_ov  = w_ef >= 13'sd2047;
    w_un  = w_ef <= 13'sd0;
    w_res = r_yz ? (r_xz ? 64'h7FF8000000000000 : {r_sign, 11'h7FF, 52'd0}) :
            r_xz ? 64'd0 :
            w_ov ? {r_sign, 11'h7FF, 52'd0} :
            w_un ? {r_sign, 63'd0} :
            {r_sign, w_ef[10:0], w_mf};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      res              <= '0;
      overflow_flag    <= 1'b0;
      underflow_flag   <= 1'b0;
      div_by_zero_flag <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= DIVIDE;
          busy    <= 1'b1;
          r_cnt   <= '0;
          r_sign  <= X[63] ^ Y[63];
          r_xz    <= ~|X[62:52];
          r_yz    <= ~|Y[62:52];
          r_exp   <= $signed({2'b0, X[62:52]}) - $signed({2'b0, Y[62:52]}) + 13'sd1023;
          r_rem   <= {1'b0, |X[62:52], X[51:0]};
          r_my    <= {1'b0, |Y[62:52], Y[51:0]};
          r_q     <= '0;
        end
        DIVIDE: begin
          r_rem <= {w_sub[52:0], 1'b0};
          r_q   <= {r_q[53:0], w_ge};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd54) r_state <= NORMALIZE;
        end
        NORMALIZE: begin
          r_state          <= DONE;
          res              <= w_res;
          div_by_zero_flag <= r_yz;
          overflow_flag    <= ~r_xz & ~r_yz & w_ov;
          underflow_flag   <= ~r_xz & ~r_yz & ~w_ov & w_un;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
      endcase
    end
  end
endmodule
